laser_highlight_ctrl: RTL and testbench

//  Controls the laser-harp display and note path. Per string it tracks beam-break events, a decaying highlight

---
 rtl/laser_harp_pkg.sv | 28 ++
 rtl/laser_rr_pick.sv | 48 ++++
 rtl/laser_highlight_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_laser_highlight_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_harp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : laser_harp_pkg
//  Description : Shared constants and types for the laser-harp display and
//                note path.
//  Revision    : 1.0  initial release
// ============================================================================
package laser_harp_pkg;

    localparam int N_STRINGS = 8;
    localparam int LEVEL_W   = 4;
    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;

    // Index width that stays legal (>=1 bit) for single-entry ranges
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [idx_width(N_STRINGS)-1:0] string_idx_t;

    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_PRESENT = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/laser_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : laser_rr_pick
//  Description : Combinational round-robin picker; returns the first pending
//                index at or after i_rr_ptr, wrapping past the top.
//  Revision    : 1.0  initial release
// ============================================================================
module laser_rr_pick
    import laser_harp_pkg::idx_width;
#(
    parameter int N_STRINGS = 8,
    parameter int IDX_W     = idx_width(N_STRINGS)
) (
    input  logic [N_STRINGS-1:0] i_pending,
    input  logic [IDX_W-1:0]     i_rr_ptr,
    output logic                 o_found,
    output logic [IDX_W-1:0]     o_idx
);

    localparam int C_SUM_W = IDX_W + 1;

    logic [2*N_STRINGS-1:0] w_dbl;
    logic [N_STRINGS-1:0]   w_rot;
    logic [C_SUM_W-1:0]     w_off;
    logic [C_SUM_W-1:0]     w_sum;
    logic [C_SUM_W-1:0]     w_wrapped;

    // Rotate so that bit 0 corresponds to the string at i_rr_ptr
    assign w_dbl = {i_pending, i_pending} >> i_rr_ptr;
    assign w_rot = w_dbl[N_STRINGS-1:0];

    always_comb begin
        o_found = 1'b0;
        w_off   = '0;
        for (int k = N_STRINGS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_found = 1'b1;
                w_off   = C_SUM_W'(k);
            end
        end
    end

    assign w_sum     = {1'b0, i_rr_ptr} + w_off;
    assign w_wrapped = (w_sum >= C_SUM_W'(N_STRINGS)) ? (w_sum - C_SUM_W'(N_STRINGS)) : w_sum;
    assign o_idx     = w_wrapped[IDX_W-1:0];

endmodule
`default_nettype wire

// File: rtl/laser_highlight_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : laser_highlight_ctrl
//  Description : Per-string beam-break tracking, decaying highlight levels,
//                raster overlay and round-robin note hand-off to the voice.
//  Revision    : 1.0  initial release
// ============================================================================
module laser_highlight_ctrl
    import laser_harp_pkg::idx_width;
    import laser_harp_pkg::V_ACTIVE;
    import laser_harp_pkg::arb_state_t;
    import laser_harp_pkg::ARB_IDLE;
    import laser_harp_pkg::ARB_PRESENT;
#(
    parameter int N_STRINGS    = 8,
    parameter int STRING_X0    = 80,
    parameter int STRING_PITCH = 64,
    parameter int STRING_W     = 8,
    parameter int LEVEL_W      = 4,
    parameter int DECAY_FRAMES = 4
) (
    input  logic                            vga_clk,
    input  logic                            reset_n,
    input  logic [9:0]                      DrawX,
    input  logic [9:0]                      DrawY,
    input  logic                            blank,
    input  logic [N_STRINGS-1:0]            string_hit,
    output logic                            hl_active,
    output logic [idx_width(N_STRINGS)-1:0] hl_string,
    output logic [LEVEL_W-1:0]              hl_level,
    output logic [N_STRINGS-1:0]            lit,
    output logic                            note_valid,
    output logic [idx_width(N_STRINGS)-1:0] note_idx,
    input  logic                            note_ready
);

    localparam int                 C_IDX_W     = idx_width(N_STRINGS);
    localparam int                 C_DIV_W     = idx_width(DECAY_FRAMES);
    localparam logic [LEVEL_W-1:0] C_LEVEL_MAX = {LEVEL_W{1'b1}};

    logic [N_STRINGS-1:0]              r_sync1, r_sync2, r_prev;
    logic [N_STRINGS-1:0]              w_hit_rise;
    logic [N_STRINGS-1:0][LEVEL_W-1:0] r_level;
    logic [N_STRINGS-1:0]              w_level_nz;
    logic [N_STRINGS-1:0]              r_lit;
    logic [C_DIV_W-1:0]                r_frame_cnt;
    logic                              w_frame_tick, w_decay;

    logic [N_STRINGS-1:0]              w_in_col;
    logic                              w_hl_active, r_hl_active;
    logic [C_IDX_W-1:0]                w_hl_string, r_hl_string;
    logic [LEVEL_W-1:0]                w_hl_level, r_hl_level;

    logic [N_STRINGS-1:0]              r_pending, w_accept;
    arb_state_t                        r_state, w_state_nxt;
    logic                              r_note_valid, w_valid_nxt;
    logic [C_IDX_W-1:0]                r_note_idx, w_idx_nxt;
    logic [C_IDX_W-1:0]                r_rr_ptr, w_rr_nxt;
    logic                              w_found;
    logic [C_IDX_W-1:0]                w_pick_idx;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= string_hit;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_hit_rise   = r_sync2 & ~r_prev;
    assign w_frame_tick = (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));
    assign w_decay      = w_frame_tick && (r_frame_cnt == C_DIV_W'(DECAY_FRAMES - 1));

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= '0;
        end else if (w_frame_tick) begin
            r_frame_cnt <= w_decay ? '0 : r_frame_cnt + 1'b1;
        end
    end

    // A held beam pins the level at max, which also makes a hit beat a decay
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level <= '0;
            r_lit   <= '0;
        end else begin
            for (int i = 0; i < N_STRINGS; i++) begin
                if (r_sync2[i]) begin
                    r_level[i] <= C_LEVEL_MAX;
                end else if (w_decay && w_level_nz[i]) begin
                    r_level[i] <= r_level[i] - 1'b1;
                end
            end
            r_lit <= w_level_nz;
        end
    end

    always_comb begin
        w_level_nz = '0;
        for (int i = 0; i < N_STRINGS; i++) begin
            w_level_nz[i] = (r_level[i] != '0);
        end
    end

    for (genvar gi = 0; gi < N_STRINGS; gi++) begin : g_col
        localparam int C_LO = STRING_X0 + gi * STRING_PITCH;
        assign w_in_col[gi] = (int'(DrawX) >= C_LO) && (int'(DrawX) < C_LO + STRING_W);
    end

    // Descending scan so the lowest lit index owns an overlapping pixel
    always_comb begin
        w_hl_active = 1'b0;
        w_hl_string = '0;
        w_hl_level  = '0;
        for (int i = N_STRINGS - 1; i >= 0; i--) begin
            if (blank && w_in_col[i] && w_level_nz[i]) begin
                w_hl_active = 1'b1;
                w_hl_string = C_IDX_W'(i);
                w_hl_level  = r_level[i];
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hl_active <= 1'b0;
            r_hl_string <= '0;
            r_hl_level  <= '0;
        end else begin
            r_hl_active <= w_hl_active;
            r_hl_string <= w_hl_string;
            r_hl_level  <= w_hl_level;
        end
    end

    always_comb begin
        w_accept = '0;
        for (int i = 0; i < N_STRINGS; i++) begin
            w_accept[i] = (r_state == ARB_PRESENT) && note_ready && (r_note_idx == C_IDX_W'(i));
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_accept) | w_hit_rise;
        end
    end

    laser_rr_pick #(
        .N_STRINGS (N_STRINGS),
        .IDX_W     (C_IDX_W)
    ) u_pick (
        .i_pending (r_pending),
        .i_rr_ptr  (r_rr_ptr),
        .o_found   (w_found),
        .o_idx     (w_pick_idx)
    );

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ARB_IDLE;
            r_note_valid <= 1'b0;
            r_note_idx   <= '0;
            r_rr_ptr     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_note_valid <= w_valid_nxt;
            r_note_idx   <= w_idx_nxt;
            r_rr_ptr     <= w_rr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_note_valid;
        w_idx_nxt   = r_note_idx;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_idx_nxt   = w_pick_idx;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ARB_PRESENT;
                end
            end
            ARB_PRESENT: begin
                if (note_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ARB_IDLE;
                    w_rr_nxt    = (r_note_idx == C_IDX_W'(N_STRINGS - 1)) ? '0 : r_note_idx + 1'b1;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    assign hl_active  = r_hl_active;
    assign hl_string  = r_hl_string;
    assign hl_level   = r_hl_level;
    assign lit        = r_lit;
    assign note_valid = r_note_valid;
    assign note_idx   = r_note_idx;

endmodule
`default_nettype wire

// File: tb/tb_laser_highlight_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_laser_highlight_ctrl
//  Description : Scoreboard bench for laser_highlight_ctrl (default params).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_laser_highlight_ctrl;

    logic       vga_clk = 1'b0;
    logic       reset_n;
    logic [9:0] DrawX, DrawY;
    logic       blank;
    logic [7:0] string_hit;
    logic       hl_active;
    logic [2:0] hl_string;
    logic [3:0] hl_level;
    logic [7:0] lit;
    logic       note_valid;
    logic [2:0] note_idx;
    logic       note_ready;

    laser_highlight_ctrl dut (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .string_hit (string_hit),
        .hl_active  (hl_active),
        .hl_string  (hl_string),
        .hl_level   (hl_level),
        .lit        (lit),
        .note_valid (note_valid),
        .note_idx   (note_idx),
        .note_ready (note_ready)
    );

    always #5 vga_clk = ~vga_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_gnt = -100;

    always @(posedge vga_clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic       act;
        logic [2:0] str;
        logic [3:0] lvl;
    } ovl_t;

    typedef struct {
        logic [2:0] idx;
        bit         chk_gap;
    } gnt_t;

    ovl_t ovl_q[$];
    gnt_t gnt_q[$];
    ovl_t mo;
    gnt_t mg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: grants and overlay responses are popped against the scoreboard
    always @(negedge vga_clk) begin
        if (reset_n && note_valid && note_ready) begin
            if (gnt_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got idx %0d expected none (t=%0t)", note_idx, $time);
            end else begin
                mg = gnt_q.pop_front();
                check("grant_idx", 32'(note_idx), 32'(mg.idx));
                if (mg.chk_gap) check("grant_gap", cyc - last_gnt, 2);
            end
            last_gnt = cyc;
        end
        while (ovl_q.size() > 0 && ovl_q[0].due <= cyc) begin
            mo = ovl_q.pop_front();
            check("ovl_active", 32'(hl_active), 32'(mo.act));
            check("ovl_string", 32'(hl_string), 32'(mo.str));
            check("ovl_level",  32'(hl_level),  32'(mo.lvl));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            #2;
        end
    endtask

    task automatic px(input int x, input int y, input bit b);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
    endtask

    task automatic px_chk(input int x, input bit b, input bit a, input int s, input int l);
        px(x, 100, b);
        ovl_q.push_back('{due: cyc + 1, act: a, str: 3'(s), lvl: 4'(l)});
        step(1);
    endtask

    // One frame tick, then park the raster on column x so hl_level shows its level
    task automatic frame_tick(input int x);
        px(0, 480, 1'b0);
        step(1);
        px(x, 100, 1'b1);
        step(1);
    endtask

    task automatic wait_valid(input int maxc);
        int n = 0;
        while (!note_valid && n < maxc) begin
            step(1);
            n++;
        end
        check("wait_note_valid", 32'(note_valid), 1);
    endtask

    task automatic push_gnt(input int idx, input bit gap);
        gnt_q.push_back('{idx: 3'(idx), chk_gap: gap});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        px(0, 0, 1'b0);
        string_hit = '0;
        note_ready = 1'b0;
        step(3);
        check("rst_hl_active",  32'(hl_active),  0);
        check("rst_hl_string",  32'(hl_string),  0);
        check("rst_hl_level",   32'(hl_level),   0);
        check("rst_lit",        32'(lit),        0);
        check("rst_note_valid", 32'(note_valid), 0);
        check("rst_note_idx",   32'(note_idx),   0);
        reset_n = 1'b1;
        step(2);

        // Reset asserted mid-frame while a note is presented
        px(528, 100, 1'b1);
        string_hit = 8'h80;
        wait_valid(10);
        check("pre_rst_idx",    32'(note_idx),  7);
        check("pre_rst_lit7",   32'(lit[7]),    1);
        check("pre_rst_active", 32'(hl_active), 1);
        #1 reset_n = 1'b0;
        #1;
        check("async_hl_active",  32'(hl_active),  0);
        check("async_hl_string",  32'(hl_string),  0);
        check("async_hl_level",   32'(hl_level),   0);
        check("async_lit",        32'(lit),        0);
        check("async_note_valid", 32'(note_valid), 0);
        check("async_note_idx",   32'(note_idx),   0);
        string_hit = '0;
        step(3);
        reset_n    = 1'b1;
        note_ready = 1'b1;
        step(12);
        check("post_rst_no_note", 32'(note_valid), 0);
        check("post_rst_lit",     32'(lit),        0);

        // Round-robin: 1,5,6 together, then 0 after wrap
        string_hit = 8'b0110_0010;
        push_gnt(1, 1'b0);
        push_gnt(5, 1'b1);
        push_gnt(6, 1'b1);
        step(12);
        string_hit = '0;
        step(3);
        string_hit = 8'h01;
        push_gnt(0, 1'b0);
        step(8);
        string_hit = '0;
        step(4);
        check("rr_grants_done", gnt_q.size(), 0);

        // Hit string 3, release, decay over 60 frame ticks
        px(272, 100, 1'b1);
        string_hit = 8'h08;
        push_gnt(3, 1'b0);
        step(3);
        check("lit3_not_yet", 32'(lit[3]), 0);
        step(1);
        check("lit3_set",     32'(lit[3]), 1);
        check("lvl3_max",     32'(hl_level), 15);
        string_hit = '0;
        step(3);
        check("lvl3_hold", 32'(hl_level), 15);
        for (int t = 1; t <= 60; t++) begin
            frame_tick(272);
            check("decay_level", 32'(hl_level), 32'(15 - t / 4));
            if (t == 59) check("lit3_still", 32'(lit[3]), 1);
            if (t == 60) begin
                check("lit3_clear",   32'(lit[3]),    0);
                check("decay_active", 32'(hl_active), 0);
            end
        end

        // Overlay on string 2 column 208..215
        string_hit = 8'h04;
        push_gnt(2, 1'b0);
        step(4);
        string_hit = '0;
        step(3);
        for (int x = 205; x <= 217; x++) begin
            if (x >= 208 && x <= 215) px_chk(x, 1'b1, 1'b1, 2, 15);
            else                      px_chk(x, 1'b1, 1'b0, 0, 0);
        end
        px_chk(210, 1'b0, 1'b0, 0, 0);
        px_chk(212, 1'b1, 1'b1, 2, 15);
        step(2);

        // Backpressure with a coalesced re-hit
        note_ready = 1'b0;
        string_hit = 8'h40;
        wait_valid(10);
        check("bp_first_idx", 32'(note_idx), 6);
        for (int i = 0; i < 10; i++) begin
            if (i == 0) string_hit = '0;
            if (i == 4) string_hit = 8'h40;
            if (i == 7) string_hit = '0;
            step(1);
            check("bp_valid", 32'(note_valid), 1);
            check("bp_idx",   32'(note_idx),   6);
        end
        step(3);
        push_gnt(6, 1'b0);
        note_ready = 1'b1;
        step(10);
        check("bp_single_grant", gnt_q.size(), 0);

        // Hit coinciding with the decay tick, then hit coinciding with acceptance
        note_ready = 1'b0;
        frame_tick(336);
        frame_tick(336);
        frame_tick(336);
        string_hit = 8'h10;
        step(2);
        px(0, 480, 1'b0);
        step(1);
        px(336, 100, 1'b1);
        step(1);
        check("hit_beats_decay", 32'(hl_level), 15);
        wait_valid(10);
        check("s4_idx", 32'(note_idx), 4);
        string_hit = '0;
        step(4);
        string_hit = 8'h10;
        step(2);
        note_ready = 1'b1;
        push_gnt(4, 1'b0);
        push_gnt(4, 1'b1);
        step(8);
        string_hit = '0;
        step(4);
        check("s4_two_grants", gnt_q.size(), 0);

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
